// File: rtl/sipo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sipo_pkg
// Brief   : shared types and helpers for the serial-in/parallel-out receiver
// Revision: 1.0
// ----------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } sipo_state_t;

  // Bit-counter width; never narrower than one bit so WIDTH=1 stays legal.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sync_fifo
// Brief   : small synchronous FIFO with a registered, zero-when-empty head
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync_fifo
  import sipo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [DATA_W-1:0]  head_q, head_d;
  logic               do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == c_depth);
  assign head_data = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a word when a pop frees a slot this cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_d = (count_d == '0) ? '0 : mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sipo_deserializer
// Brief   : framed serial bit stream to WIDTH-bit words on a valid/ready port
// Revision: 1.0
// ----------------------------------------------------------------------------
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow
);

  localparam int c_cnt_w = cnt_w(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  sipo_state_t        state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d, shift_in;
  logic               frame_err_q, frame_err_d;
  logic               overflow_q, overflow_d;
  logic               push, pop, fifo_empty, fifo_full;
  logic [WIDTH-1:0]   head_data;

  // shift_in is the register contents including the bit arriving this cycle.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = (shift_q << 1) | WIDTH'(bit_data);
    end else begin : g_lsb_first
      assign shift_in = (shift_q >> 1) | (WIDTH'(bit_data) << (WIDTH - 1));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (frame_start) begin
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          shift_d     = '0;
        end else if (bit_valid) begin
          if (cnt_q == c_last) begin
            push    = 1'b1;
            cnt_d   = '0;
            shift_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shift_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop        = word_valid && word_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_in),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign word_valid = !fifo_empty;
  assign word_data  = head_data;
  assign busy       = (state_q == RECV);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire
